// File: rtl/jtkcpu_memop_if.sv
// jtkcpu_memop_if
//   Groups the sequencer handshake, the ALU operand/result path and the
//   byte-wide CPU bus used by jtkcpu_memop.
//   slave  : the memop block (drives bus_*, opnd1, opnd_valid, busy)
//   master : whoever drives start/mode/len16/addr/wdata, cen and the bus
//            response (bus_din, bus_wait)
interface jtkcpu_memop_if #(
  parameter int AW = 16
);
  logic          cen;
  logic          start;
  logic [1:0]    mode;
  logic          len16;
  logic [AW-1:0] addr;
  logic [15:0]   wdata;
  logic [7:0]    bus_din;
  logic          bus_wait;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_dout;
  logic          bus_we;
  logic          bus_rd;
  logic [15:0]   opnd1;
  logic          opnd_valid;
  logic          busy;

  modport slave (
    input  cen, start, mode, len16, addr, wdata, bus_din, bus_wait,
    output bus_addr, bus_dout, bus_we, bus_rd, opnd1, opnd_valid, busy
  );

  modport master (
    output cen, start, mode, len16, addr, wdata, bus_din, bus_wait,
    input  bus_addr, bus_dout, bus_we, bus_rd, opnd1, opnd_valid, busy
  );
endinterface

// File: rtl/jtkcpu_memop.sv
// jtkcpu_memop
//   Memory-operand sequencer around the ALU. Fetches an 8/16-bit big-endian
//   operand over the byte bus into opnd1, gives the ALU one EXEC cycle, then
//   writes the ALU result back for store and read-modify-write forms.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   io    : jtkcpu_memop_if.slave
//           cen        clock enable qualifying every state change
//           start/mode/len16/addr : operation request (IDLE only)
//           wdata      ALU result, captured at the end of EXEC
//           bus_din/bus_wait      : bus read data / stall
//           bus_addr/bus_dout/bus_we/bus_rd : registered bus request
//           opnd1/opnd_valid      : fetched operand and completion pulse
//           busy       high outside IDLE
module jtkcpu_memop #(
  parameter int AW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  jtkcpu_memop_if.slave  io
);

  typedef enum logic [2:0] {
    IDLE,
    RD_HI,
    RD_LO,
    EXEC,
    WR_HI,
    WR_LO
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          len16_q, len16_d;
  logic          rmw_q, rmw_d;
  logic [7:0]    wlo_q, wlo_d;        // low result byte, sent in WR_LO
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [7:0]    bus_dout_q, bus_dout_d;
  logic [15:0]   opnd1_q, opnd1_d;
  logic          valid_q, valid_d;

  logic          advance;
  logic [AW-1:0] addr_inc;

  // Bus states only move when enabled and not stalled.
  assign advance  = io.cen & ~io.bus_wait;
  // Second byte address; wraps naturally at AW bits.
  assign addr_inc = addr_q + AW'(1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len16_d    = len16_q;
    rmw_d      = rmw_q;
    wlo_d      = wlo_q;
    bus_addr_d = bus_addr_q;
    bus_dout_d = bus_dout_q;
    opnd1_d    = opnd1_q;
    valid_d    = valid_q;

    // opnd_valid lasts exactly one enabled cycle.
    if (io.cen && valid_q) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (io.cen && io.start) begin
          addr_d     = io.addr;
          len16_d    = io.len16;
          rmw_d      = (io.mode == 2'd2);
          bus_addr_d = io.addr;
          if (io.mode == 2'd1) begin
            // Store: no fetch, go straight to the ALU cycle.
            state_d = EXEC;
          end else if (io.len16) begin
            state_d = RD_HI;
          end else begin
            state_d = RD_LO;
          end
        end
      end

      RD_HI: begin
        if (advance) begin
          opnd1_d[15:8] = io.bus_din;
          bus_addr_d    = addr_inc;
          state_d       = RD_LO;
        end
      end

      RD_LO: begin
        if (advance) begin
          opnd1_d[7:0] = io.bus_din;
          if (!len16_q) begin
            opnd1_d[15:8] = 8'h00;
          end
          valid_d = 1'b1;
          state_d = rmw_q ? EXEC : IDLE;
        end
      end

      EXEC: begin
        // ALU settles during this cycle; the bus is idle so a stall is moot.
        if (io.cen) begin
          wlo_d      = io.wdata[7:0];
          bus_addr_d = addr_q;
          if (len16_q) begin
            bus_dout_d = io.wdata[15:8];
            state_d    = WR_HI;
          end else begin
            bus_dout_d = io.wdata[7:0];
            state_d    = WR_LO;
          end
        end
      end

      WR_HI: begin
        if (advance) begin
          bus_addr_d = addr_inc;
          bus_dout_d = wlo_q;
          state_d    = WR_LO;
        end
      end

      WR_LO: begin
        if (advance) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len16_q    <= 1'b0;
      rmw_q      <= 1'b0;
      wlo_q      <= 8'h00;
      bus_addr_q <= '0;
      bus_dout_q <= 8'h00;
      opnd1_q    <= 16'h0000;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len16_q    <= len16_d;
      rmw_q      <= rmw_d;
      wlo_q      <= wlo_d;
      bus_addr_q <= bus_addr_d;
      bus_dout_q <= bus_dout_d;
      opnd1_q    <= opnd1_d;
      valid_q    <= valid_d;
    end
  end

  // Strobes are decoded from the registered state, so they are glitch-free
  // and mutually exclusive by construction.
  assign io.bus_rd     = (state_q == RD_HI) || (state_q == RD_LO);
  assign io.bus_we     = (state_q == WR_HI) || (state_q == WR_LO);
  assign io.busy       = (state_q != IDLE);
  assign io.bus_addr   = bus_addr_q;
  assign io.bus_dout   = bus_dout_q;
  assign io.opnd1      = opnd1_q;
  assign io.opnd_valid = valid_q;

endmodule
